dsp_nco_sweep_ctrl: RTL and testbench
=====================================

DSP_NCO_SWEEP_CTRL -- requirements
Module: dsp_nco_sweep_ctrl

Interface
REQ-001 Parameter PHI_WIDTH, default 32: width of the NCO phase increment word.
REQ-002 Parameter DWELL_WIDTH, default 16: width of the per-step dwell count.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_valid  input  1  configuration offer.
REQ-006 cfg_ready  output  1  configuration accept; high only in IDLE or ARMED.
REQ-007 cfg_start / cfg_stop / cfg_step  input  PHI_WIDTH each  sweep start, stop and step increments, all unsigned.
REQ-008 cfg_dwell  input  DWELL_WIDTH  each increment is held for cfg_dwell+1 cycles.
REQ-009 cfg_mode  input  2  sweep mode: 0 single, 1 sawtooth repeat, 2 triangle repeat, 3 reserved (behaves as 0).
REQ-010 start  input  1  begin sweep.
REQ-011 abort  input  1  stop sweep.
REQ-012 nco_en  output  1  drives the NCO en input.
REQ-013 phi_inc  output  PHI_WIDTH  drives the NCO phi_inc input.
REQ-014 busy  output  1  high in SWEEP_UP or SWEEP_DN.
REQ-015 done  output  1  one-cycle pulse at the end of a single-mode sweep.
REQ-016 wrap  output  1  one-cycle pulse at each repeat-mode period restart.
REQ-017 cfg_err  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-018 The controller SHALL have states IDLE, ARMED, SWEEP_UP and SWEEP_DN; all outputs SHALL be registered.
REQ-019 Configuration handshake:
- Transfer occurs on an edge with cfg_valid && cfg_ready.
- The accepted values SHALL be latched into shadow registers and the state SHALL become ARMED.
REQ-020 A transfer with cfg_start > cfg_stop SHALL be rejected:
- cfg_err pulses.
- Shadow registers and state are unchanged.
REQ-021 Start:
- start is ignored in IDLE, SWEEP_UP and SWEEP_DN.
- start sampled high in ARMED SHALL, from that edge, drive nco_en=1, busy=1 and phi_inc=shadow start, and enter SWEEP_UP.
REQ-022 Dwell:
- Each phi_inc value SHALL be held for exactly dwell+1 consecutive cycles.
- A dwell counter counts 0..dwell and restarts on every value change.
REQ-023 SWEEP_UP step, at dwell end with phi_inc < stop:
- next = phi_inc + step, computed at PHI_WIDTH+1 bits.
- next SHALL clamp to stop when it is >= stop, including on carry-out.
REQ-024 SWEEP_UP at dwell end with phi_inc == stop:
- Mode 0/3: next edge SHALL give state ARMED, nco_en=0, busy=0, phi_inc=0, done=1 for one cycle.
- Mode 1: phi_inc SHALL reload start and wrap pulses.
- Mode 2: the state SHALL become SWEEP_DN, with next = stop - step clamped to start (no underflow).
REQ-025 SWEEP_DN:
- SHALL decrement with the same clamp until phi_inc == start.
- At dwell end with phi_inc == start, the state SHALL become SWEEP_UP, with next = start + step clamped per REQ-023, and wrap pulses.
REQ-026 Degenerate cases:
- step=0 with start<stop SHALL hold start indefinitely until abort.
- start==stop: mode 0 emits dwell+1 cycles then done.
- start==stop: modes 1/2 pulse wrap every dwell+1 cycles with phi_inc constant.
REQ-027 abort sampled high in SWEEP_UP or SWEEP_DN:
- Next edge SHALL give ARMED, nco_en=0, busy=0, phi_inc=0.
- No done and no wrap.
- abort SHALL take priority over start and dwell-end events in the same cycle; abort in IDLE or ARMED has no effect.
REQ-028 A configuration transfer in ARMED SHALL replace the shadow registers; if start is high in the same cycle, the sweep SHALL start with the old values.
REQ-029 Config inputs SHALL NOT affect an active sweep; only the shadow registers are used.

Reset
REQ-030 rst_n low SHALL immediately force:
- state IDLE; nco_en=0, busy=0, done=0, wrap=0, cfg_err=0, phi_inc=0, cfg_ready=0.
- Shadow registers and dwell counter cleared.
REQ-031 On the first edge after rst_n deasserts, cfg_ready SHALL be 1.
REQ-032 Reset mid-sweep SHALL behave identically to REQ-030 with no done pulse; after release, start is ignored until a configuration is accepted.

Verification
REQ-033 Single sweep:
- Stimulus: start=100, stop=130, step=10, dwell=2, mode 0, then start.
- Response: phi_inc 100,110,120,130 each for 3 cycles (12 nco_en cycles), then done pulse, phi_inc=0, state ARMED.
REQ-034 Clamp and overflow:
- start=100, stop=125, step=10, dwell=0 -> 100,110,120,125 then done.
- PHI_WIDTH=32, start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20 -> 0xFFFFFFF0, 0xFFFFFFFF then done.
REQ-035 Triangle:
- Stimulus: start=0, stop=10, step=5, dwell=0, mode 2.
- Response: 0,5,10,5,0,5,10,...; wrap pulses on each 0->5 transition; no done.
REQ-036 Abort:
- Stimulus: abort together with start in the 4th cycle of REQ-033.
- Response: next cycle nco_en=0, phi_inc=0, no done; a second start replays the sweep from 100.
REQ-037 Config error and reset:
- start=50, stop=40 -> cfg_err pulse, state unchanged.
- rst_n low mid-sweep -> all outputs 0 asynchronously, cfg_ready=1 after release.

Source files
------------

// File: rtl/dsp_nco_sweep_ctrl.sv
// dsp_nco_sweep_ctrl: steps an NCO phase increment from start to stop.
// Supports single, sawtooth and triangle sweeps with a per-step dwell.
module dsp_nco_sweep_ctrl #(
   parameter int PHI_WIDTH   = 32,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [PHI_WIDTH-1:0]   cfg_start,
   input  logic [PHI_WIDTH-1:0]   cfg_stop,
   input  logic [PHI_WIDTH-1:0]   cfg_step,
   input  logic [DWELL_WIDTH-1:0] cfg_dwell,
   input  logic [1:0]             cfg_mode,
   input  logic                   start,
   input  logic                   abort,
   output logic                   nco_en,
   output logic [PHI_WIDTH-1:0]   phi_inc,
   output logic                   busy,
   output logic                   done,
   output logic                   wrap,
   output logic                   cfg_err
);

   localparam int W = PHI_WIDTH;
   localparam int D = DWELL_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      SWEEP_UP,
      SWEEP_DN
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0] sh_start_q, sh_start_d;
   logic [W-1:0] sh_stop_q, sh_stop_d;
   logic [W-1:0] sh_step_q, sh_step_d;
   logic [D-1:0] sh_dwell_q, sh_dwell_d;
   logic [1:0]   sh_mode_q, sh_mode_d;

   logic [W-1:0] act_start_q, act_start_d;
   logic [W-1:0] act_stop_q, act_stop_d;
   logic [W-1:0] act_step_q, act_step_d;
   logic [D-1:0] act_dwell_q, act_dwell_d;
   logic [1:0]   act_mode_q, act_mode_d;

   logic [W-1:0] phi_q, phi_d;
   logic [D-1:0] cnt_q, cnt_d;
   logic         en_q, en_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         wrap_q, wrap_d;
   logic         err_q, err_d;
   logic         rdy_q, rdy_d;

   logic         xfer;
   logic         dwell_end;
   logic         sweeping;
   logic [W:0]   up_sum;
   logic [W:0]   dn_diff;
   logic [W-1:0] up_next;
   logic [W-1:0] dn_next;

   assign xfer      = cfg_valid && rdy_q;
   assign dwell_end = (cnt_q == act_dwell_q);
   assign sweeping  = (state_q == SWEEP_UP) || (state_q == SWEEP_DN);

   // Extra bit catches carry-out / borrow so both directions clamp cleanly.
   assign up_sum  = {1'b0, phi_q} + {1'b0, act_step_q};
   assign dn_diff = {1'b0, phi_q} - {1'b0, act_step_q};
   assign up_next = (up_sum >= {1'b0, act_stop_q}) ? act_stop_q
                                                   : up_sum[W-1:0];
   assign dn_next = (dn_diff[W] || (dn_diff[W-1:0] <= act_start_q))
                  ? act_start_q : dn_diff[W-1:0];

   always_comb begin
      state_d     = state_q;
      sh_start_d  = sh_start_q;
      sh_stop_d   = sh_stop_q;
      sh_step_d   = sh_step_q;
      sh_dwell_d  = sh_dwell_q;
      sh_mode_d   = sh_mode_q;
      act_start_d = act_start_q;
      act_stop_d  = act_stop_q;
      act_step_d  = act_step_q;
      act_dwell_d = act_dwell_q;
      act_mode_d  = act_mode_q;
      phi_d       = phi_q;
      cnt_d       = cnt_q;
      en_d        = en_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      wrap_d      = 1'b0;
      err_d       = 1'b0;

      if (sweeping && abort) begin
         state_d = ARMED;
         en_d    = 1'b0;
         busy_d  = 1'b0;
         phi_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE, ARMED: begin
               if (xfer) begin
                  if (cfg_start > cfg_stop) begin
                     err_d = 1'b1;
                  end else begin
                     sh_start_d = cfg_start;
                     sh_stop_d  = cfg_stop;
                     sh_step_d  = cfg_step;
                     sh_dwell_d = cfg_dwell;
                     sh_mode_d  = cfg_mode;
                     state_d    = ARMED;
                  end
               end
               // Start snapshots the pre-transfer shadow set.
               if ((state_q == ARMED) && start) begin
                  act_start_d = sh_start_q;
                  act_stop_d  = sh_stop_q;
                  act_step_d  = sh_step_q;
                  act_dwell_d = sh_dwell_q;
                  act_mode_d  = sh_mode_q;
                  phi_d       = sh_start_q;
                  cnt_d       = '0;
                  en_d        = 1'b1;
                  busy_d      = 1'b1;
                  state_d     = SWEEP_UP;
               end
            end
            SWEEP_UP: begin
               if (!dwell_end) begin
                  cnt_d = cnt_q + D'(1);
               end else begin
                  cnt_d = '0;
                  if (phi_q < act_stop_q) begin
                     phi_d = up_next;
                  end else if (act_mode_q == 2'd1) begin
                     phi_d  = act_start_q;
                     wrap_d = 1'b1;
                  end else if (act_mode_q == 2'd2) begin
                     if (act_start_q == act_stop_q) begin
                        wrap_d = 1'b1;
                     end else begin
                        phi_d   = dn_next;
                        state_d = SWEEP_DN;
                     end
                  end else begin
                     phi_d   = '0;
                     en_d    = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = ARMED;
                  end
               end
            end
            SWEEP_DN: begin
               if (!dwell_end) begin
                  cnt_d = cnt_q + D'(1);
               end else begin
                  cnt_d = '0;
                  if (phi_q > act_start_q) begin
                     phi_d = dn_next;
                  end else begin
                     phi_d   = up_next;
                     wrap_d  = 1'b1;
                     state_d = SWEEP_UP;
                  end
               end
            end
         endcase
      end

      rdy_d = (state_d == IDLE) || (state_d == ARMED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sh_start_q  <= '0;
         sh_stop_q   <= '0;
         sh_step_q   <= '0;
         sh_dwell_q  <= '0;
         sh_mode_q   <= '0;
         act_start_q <= '0;
         act_stop_q  <= '0;
         act_step_q  <= '0;
         act_dwell_q <= '0;
         act_mode_q  <= '0;
         phi_q       <= '0;
         cnt_q       <= '0;
         en_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_start_q  <= sh_start_d;
         sh_stop_q   <= sh_stop_d;
         sh_step_q   <= sh_step_d;
         sh_dwell_q  <= sh_dwell_d;
         sh_mode_q   <= sh_mode_d;
         act_start_q <= act_start_d;
         act_stop_q  <= act_stop_d;
         act_step_q  <= act_step_d;
         act_dwell_q <= act_dwell_d;
         act_mode_q  <= act_mode_d;
         phi_q       <= phi_d;
         cnt_q       <= cnt_d;
         en_q        <= en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wrap_q      <= wrap_d;
         err_q       <= err_d;
         rdy_q       <= rdy_d;
      end
   end

   assign cfg_ready = rdy_q;
   assign nco_en    = en_q;
   assign phi_inc   = phi_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrap      = wrap_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_dsp_nco_sweep_ctrl.sv
// tb_dsp_nco_sweep_ctrl: scoreboard bench for the NCO sweep controller.
// Expected per-cycle outputs are queued with each start and popped on negedge.
module tb_dsp_nco_sweep_ctrl;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [31:0] cfg_start = '0;
   logic [31:0] cfg_stop  = '0;
   logic [31:0] cfg_step  = '0;
   logic [15:0] cfg_dwell = '0;
   logic [1:0]  cfg_mode  = '0;
   logic        start     = 1'b0;
   logic        abort     = 1'b0;
   logic        nco_en;
   logic [31:0] phi_inc;
   logic        busy;
   logic        done;
   logic        wrap;
   logic        cfg_err;

   typedef struct {
      logic [31:0] phi;
      logic        en;
      logic        dn;
      logic        wr;
      logic        wx;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   dsp_nco_sweep_ctrl #(.PHI_WIDTH(32), .DWELL_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_start (cfg_start),
      .cfg_stop  (cfg_stop),
      .cfg_step  (cfg_step),
      .cfg_dwell (cfg_dwell),
      .cfg_mode  (cfg_mode),
      .start     (start),
      .abort     (abort),
      .nco_en    (nco_en),
      .phi_inc   (phi_inc),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (phi_inc !== e.phi) begin
            n_fail++;
            $display("FAIL sb_phi_inc @%0t: got %h, expected %h",
                     $time, phi_inc, e.phi);
         end
         n_checks++;
         if (nco_en !== e.en) begin
            n_fail++;
            $display("FAIL sb_nco_en @%0t: got %b, expected %b",
                     $time, nco_en, e.en);
         end
         n_checks++;
         if (busy !== e.en) begin
            n_fail++;
            $display("FAIL sb_busy @%0t: got %b, expected %b",
                     $time, busy, e.en);
         end
         n_checks++;
         if (cfg_ready !== !e.en) begin
            n_fail++;
            $display("FAIL sb_cfg_ready @%0t: got %b, expected %b",
                     $time, cfg_ready, !e.en);
         end
         n_checks++;
         if (done !== e.dn) begin
            n_fail++;
            $display("FAIL sb_done @%0t: got %b, expected %b",
                     $time, done, e.dn);
         end
         if (!e.wx) begin
            n_checks++;
            if (wrap !== e.wr) begin
               n_fail++;
               $display("FAIL sb_wrap @%0t: got %b, expected %b",
                        $time, wrap, e.wr);
            end
         end
      end
   end

   function automatic void push(input logic [31:0] p, input logic en,
                                input logic dn = 1'b0,
                                input logic wr = 1'b0,
                                input logic wx = 1'b0);
      exp_t e;
      e.phi = p;
      e.en  = en;
      e.dn  = dn;
      e.wr  = wr;
      e.wx  = wx;
      sb.push_back(e);
   endfunction

   function automatic void push_single_100_130();
      for (int v = 100; v <= 130; v += 10)
         repeat (3) push(32'(v), 1'b1);
      push(32'd0, 1'b0, 1'b1);
      push(32'd0, 1'b0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [31:0] s, input logic [31:0] e,
                         input logic [31:0] st, input logic [15:0] d,
                         input logic [1:0] m);
      cfg_start = s;
      cfg_stop  = e;
      cfg_step  = st;
      cfg_dwell = d;
      cfg_mode  = m;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() > 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: %0d entries left, expected 0",
                  name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (phi_inc !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_phi: got %h, expected 0", phi_inc);
      end
      n_checks++;
      if ({nco_en, busy, done, wrap, cfg_err, cfg_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, expected 000000",
                  {nco_en, busy, done, wrap, cfg_err, cfg_ready});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      n_checks++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b, expected 1", cfg_ready);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({nco_en, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_start_ignored: got %b, expected 00",
                  {nco_en, busy});
      end
   endtask

   task automatic test_single();
      do_cfg(32'd100, 32'd130, 32'd10, 16'd2, 2'd0);
      n_checks++;
      if ({cfg_err, cfg_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL single_cfg: err/ready got %b, expected 01",
                  {cfg_err, cfg_ready});
      end
      push(32'd0, 1'b0);
      push_single_100_130();
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("single");
   endtask

   task automatic test_clamp();
      do_cfg(32'd100, 32'd125, 32'd10, 16'd0, 2'd3);
      push(32'd0, 1'b0);
      push(32'd100, 1'b1);
      push(32'd110, 1'b1);
      push(32'd120, 1'b1);
      push(32'd125, 1'b1);
      push(32'd0, 1'b0, 1'b1);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("clamp");
   endtask

   task automatic test_overflow();
      do_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 2'd0);
      push(32'd0, 1'b0);
      push(32'hFFFF_FFF0, 1'b1);
      push(32'hFFFF_FFFF, 1'b1);
      push(32'd0, 1'b0, 1'b1);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("overflow");
   endtask

   task automatic test_triangle();
      int seq[10];
      seq = '{0, 5, 10, 5, 0, 5, 10, 5, 0, 5};
      do_cfg(32'd0, 32'd10, 32'd5, 16'd0, 2'd2);
      push(32'd0, 1'b0);
      for (int i = 0; i < 10; i++)
         push(32'(seq[i]), 1'b1, 1'b0, (i == 5) || (i == 9), i == 1);
      push(32'd0, 1'b0);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      drain("triangle");
   endtask

   task automatic test_sawtooth();
      do_cfg(32'd0, 32'd4, 32'd2, 16'd0, 2'd1);
      push(32'd0, 1'b0);
      push(32'd0, 1'b1);
      push(32'd2, 1'b1);
      push(32'd4, 1'b1);
      push(32'd0, 1'b1, 1'b0, 1'b1);
      push(32'd2, 1'b1);
      push(32'd4, 1'b1);
      push(32'd0, 1'b1, 1'b0, 1'b1);
      push(32'd0, 1'b0);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      drain("sawtooth");
   endtask

   task automatic test_degenerate();
      for (int m = 1; m <= 2; m++) begin
         do_cfg(32'd7, 32'd7, 32'd3, 16'd1, 2'(m));
         push(32'd0, 1'b0);
         for (int i = 0; i < 6; i++)
            push(32'd7, 1'b1, 1'b0, (i == 2) || (i == 4));
         push(32'd0, 1'b0);
         push(32'd0, 1'b0);
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (5) tick();
         abort = 1'b1;
         tick();
         abort = 1'b0;
         drain("equal_repeat");
      end
      do_cfg(32'd7, 32'd7, 32'd3, 16'd1, 2'd0);
      push(32'd0, 1'b0);
      push(32'd7, 1'b1);
      push(32'd7, 1'b1);
      push(32'd0, 1'b0, 1'b1);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("equal_single");
      do_cfg(32'd5, 32'd9, 32'd0, 16'd0, 2'd0);
      push(32'd0, 1'b0);
      repeat (20) push(32'd5, 1'b1);
      push(32'd0, 1'b0);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      drain("step_zero");
   endtask

   task automatic test_abort();
      do_cfg(32'd100, 32'd130, 32'd10, 16'd2, 2'd0);
      push(32'd0, 1'b0);
      repeat (3) push(32'd100, 1'b1);
      push(32'd110, 1'b1);
      push(32'd0, 1'b0);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      drain("abort");
      tick();
      push(32'd0, 1'b0);
      push_single_100_130();
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("abort_replay");
   endtask

   task automatic test_cfg_err();
      do_cfg(32'd50, 32'd40, 32'd1, 16'd0, 2'd0);
      n_checks++;
      if ({cfg_err, cfg_ready, busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL cfg_err_pulse: err/ready/busy got %b, expected 110",
                  {cfg_err, cfg_ready, busy});
      end
      tick();
      n_checks++;
      if (cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_err_width: got %b, expected 0", cfg_err);
      end
      push(32'd0, 1'b0);
      push_single_100_130();
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("cfg_err_keep");
   endtask

   task automatic test_back_to_back();
      cfg_start = 32'd200;
      cfg_stop  = 32'd201;
      cfg_step  = 32'd1;
      cfg_dwell = 16'd0;
      cfg_mode  = 2'd0;
      cfg_valid = 1'b1;
      start     = 1'b1;
      push(32'd0, 1'b0);
      push_single_100_130();
      tick();
      start     = 1'b0;
      cfg_start = 32'd0;
      cfg_stop  = 32'd1;
      repeat (5) tick();
      cfg_valid = 1'b0;
      drain("cfg_with_start");
      tick();
      push(32'd0, 1'b0);
      push(32'd200, 1'b1);
      push(32'd201, 1'b1);
      push(32'd0, 1'b0, 1'b1);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("new_cfg");
   endtask

   task automatic test_reset_mid_sweep();
      do_cfg(32'd100, 32'd130, 32'd10, 16'd2, 2'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_sweep_busy: got %b, expected 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (phi_inc !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset_phi: got %h, expected 0", phi_inc);
      end
      n_checks++;
      if ({nco_en, busy, done, wrap, cfg_err, cfg_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL async_reset_flags: got %b, expected 000000",
                  {nco_en, busy, done, wrap, cfg_err, cfg_ready});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      n_checks++;
      if ({cfg_ready, done, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL post_reset: ready/done/busy got %b, expected 100",
                  {cfg_ready, done, busy});
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({nco_en, busy, phi_inc} !== 34'd0) begin
         n_fail++;
         $display("FAIL post_reset_start: en/busy/phi got %h, expected 0",
                  {nco_en, busy, phi_inc});
      end
      do_cfg(32'd0, 32'd0, 32'd0, 16'd0, 2'd0);
      push(32'd0, 1'b0);
      push(32'd0, 1'b1);
      push(32'd0, 1'b0, 1'b1);
      push(32'd0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("post_reset_sweep");
   endtask

   initial begin
      test_reset();
      test_single();
      test_clamp();
      test_overflow();
      test_triangle();
      test_sawtooth();
      test_degenerate();
      test_abort();
      test_cfg_err();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
